// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DBIT data bits LSB-first, configurable stop period,
// paced by the baud generator's oversampling tick.
module uart_tx_frame #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned NB_TICK = 16,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_s_tick,
  input  logic            i_tx_start,
  input  logic [DBIT-1:0] i_data_in,
  output logic            o_tx,
  output logic            o_tx_busy,
  output logic            o_tx_done_tick
);

  localparam int unsigned S_MAX = ((NB_TICK > SB_TICK) ? NB_TICK : SB_TICK) - 1;
  localparam int unsigned SW    = (S_MAX > 0) ? $clog2(S_MAX + 1) : 1;
  localparam int unsigned NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(NB_TICK - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic [DBIT-1:0] b_shift;
  logic            tx_reg;
  logic            busy_reg;

  assign b_shift = b >> 1;

  // Done is decoded from registered state and the live tick so it coincides with the
  // last STOP cycle; a start request in that same cycle therefore still sees STOP.
  assign o_tx_done_tick = (state == STOP) && i_s_tick && (s == S_STOP_LAST);
  assign o_tx           = tx_reg;
  assign o_tx_busy      = busy_reg;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state    <= IDLE;
      s        <= '0;
      n        <= '0;
      b        <= '0;
      tx_reg   <= 1'b1;
      busy_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
          if (i_tx_start) begin
            b        <= i_data_in;
            s        <= '0;
            state    <= START;
            tx_reg   <= 1'b0;
            busy_reg <= 1'b1;
          end
        end
        START: begin
          if (i_s_tick) begin
            if (s == S_BIT_LAST) begin
              s      <= '0;
              n      <= '0;
              state  <= DATA;
              tx_reg <= b[0];
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (i_s_tick) begin
            if (s == S_BIT_LAST) begin
              s <= '0;
              b <= b_shift;
              if (n == N_LAST) begin
                state  <= STOP;
                tx_reg <= 1'b1;
              end else begin
                n      <= n + 1'b1;
                tx_reg <= b_shift[0];
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (i_s_tick) begin
            if (s == S_STOP_LAST) begin
              s        <= '0;
              state    <= IDLE;
              busy_reg <= 1'b0;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: table of frames plus hand-written corner sequences.
module tb_uart_tx_frame;

  logic       i_clk;
  logic       i_reset;
  logic       i_s_tick;
  logic       i_tx_start, i_tx_start2;
  logic [7:0] i_data_in, i_data_in2;
  logic       tx1, busy1, done1;
  logic       tx2, busy2, done2;
  logic       sel;
  logic       mon_tx, mon_busy, mon_done;

  uart_tx_frame #(.DBIT(8), .NB_TICK(16), .SB_TICK(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_s_tick(i_s_tick), .i_tx_start(i_tx_start),
    .i_data_in(i_data_in), .o_tx(tx1), .o_tx_busy(busy1), .o_tx_done_tick(done1));

  uart_tx_frame #(.DBIT(8), .NB_TICK(16), .SB_TICK(32)) dut_sb32 (
    .i_clk(i_clk), .i_reset(i_reset), .i_s_tick(i_s_tick), .i_tx_start(i_tx_start2),
    .i_data_in(i_data_in2), .o_tx(tx2), .o_tx_busy(busy2), .o_tx_done_tick(done2));

  assign mon_tx   = sel ? tx2   : tx1;
  assign mon_busy = sel ? busy2 : busy1;
  assign mon_done = sel ? done2 : done1;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int          stall_cnt = 0;
  logic        tick_now = 1'b0;

  typedef struct {
    logic [7:0]  data;
    logic        sb32;
    logic [9:0]  exp_bits;   // [0]=start, [1..8]=d0..d7, [9]=stop level
    int unsigned sb_ticks;
    int          exp_clks;   // clocks from accept edge to the edge ending the last tick
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Tick on every 4th clock unless a stall is in progress.
  task automatic drive_tick();
    tick_now = (stall_cnt == 0) && (cyc % 4 == 0);
    if (stall_cnt > 0) stall_cnt--;
    i_s_tick = tick_now;
  endtask

  task automatic cycle();
    drive_tick();
    #1;
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [7:0] d, input logic use2, input logic hold);
    while (cyc % 4 != 0) cycle();
    if (use2) begin i_data_in2 = d; i_tx_start2 = 1'b1; end
    else      begin i_data_in  = d; i_tx_start  = 1'b1; end
    cycle();
    if (!hold) begin i_tx_start = 1'b0; i_tx_start2 = 1'b0; end
  endtask

  // Follows the frame by counted ticks, so it stays valid across tick stalls.
  task automatic check_frame(input logic [9:0] eb, input int unsigned sbt, input int exp_clks,
                             input int stall_k, input int poke_k, input string name);
    int unsigned k, total, seg;
    int clk_t, busy_err, done_cnt, done_err;
    int err [10];
    logic stalled, poked, poke_pending;
    k = 0; total = 144 + sbt; clk_t = 0;
    busy_err = 0; done_cnt = 0; done_err = 0;
    stalled = 1'b0; poked = 1'b0; poke_pending = 1'b0;
    for (int i = 0; i < 10; i++) err[i] = 0;
    while (k < total && clk_t < exp_clks + 200) begin
      if (poke_pending) begin i_tx_start = 1'b0; poke_pending = 1'b0; end
      if (stall_k >= 0 && !stalled && k == unsigned'(stall_k)) begin
        stall_cnt = 50; stalled = 1'b1;
      end
      if (poke_k >= 0 && !poked && k == unsigned'(poke_k)) begin
        i_data_in = 8'hC3; i_tx_start = 1'b1; poked = 1'b1; poke_pending = 1'b1;
      end
      drive_tick();
      #1;
      seg = (k < 144) ? k / 16 : 9;
      if (mon_tx !== eb[seg]) err[seg]++;
      if (mon_busy !== 1'b1) busy_err++;
      if (mon_done === 1'b1) done_cnt++;
      if (mon_done !== (tick_now && k == total - 1)) done_err++;
      @(posedge i_clk);
      #1;
      cyc++;
      clk_t++;
      if (tick_now) k++;
    end
    for (int i = 0; i < 10; i++) check($sformatf("%s_bit%0d_errs", name, i), err[i], 0);
    check({name, "_busy_errs"}, busy_err, 0);
    check({name, "_done_timing_errs"}, done_err, 0);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_frame_clks"}, clk_t, exp_clks);
    check({name, "_idle_tx"}, mon_tx, 1);
    check({name, "_idle_busy"}, mon_busy, 0);
  endtask

  initial begin
    int k, g, low_cnt, busy_cnt, dn_cnt;

    vecs[0] = '{data: 8'hA5, sb32: 1'b0, exp_bits: 10'b1101001010, sb_ticks: 16, exp_clks: 640};
    vecs[1] = '{data: 8'h81, sb32: 1'b1, exp_bits: 10'b1100000010, sb_ticks: 32, exp_clks: 704};
    vecs[2] = '{data: 8'h55, sb32: 1'b0, exp_bits: 10'b1010101010, sb_ticks: 16, exp_clks: 640};

    sel = 1'b0; i_reset = 1'b0; i_s_tick = 1'b0;
    i_tx_start = 1'b0; i_tx_start2 = 1'b0; i_data_in = 8'h00; i_data_in2 = 8'h00;

    repeat (3) cycle();
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #0;
      check($sformatf("reset_tx_dut%0d", d), mon_tx, 1);
      check($sformatf("reset_busy_dut%0d", d), mon_busy, 0);
      check($sformatf("reset_done_dut%0d", d), mon_done, 0);
    end
    sel = 1'b0;
    i_reset = 1'b1;
    repeat (4) cycle();

    for (int i = 0; i < 3; i++) begin
      sel = vecs[i].sb32;
      send(vecs[i].data, vecs[i].sb32, 1'b0);
      check_frame(vecs[i].exp_bits, vecs[i].sb_ticks, vecs[i].exp_clks, -1, -1,
                  $sformatf("vec%0d", i));
      repeat (5) cycle();
    end
    sel = 1'b0;

    // Back-to-back with start held: accept edge of frame 2 is off the tick phase.
    send(8'h00, 1'b0, 1'b1);
    check_frame(10'b1000000000, 16, 640, -1, -1, "b2b_00");
    i_data_in = 8'hFF;
    cycle();
    check("b2b_gap_start_bit", tx1, 0);
    check_frame(10'b1111111110, 16, 639, -1, -1, "b2b_ff");
    i_tx_start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin cycle(); if (busy1 !== 1'b0) busy_cnt++; end
    check("b2b_no_third_frame", busy_cnt, 0);

    // Start and new data while busy must be ignored.
    send(8'h3C, 1'b0, 1'b0);
    check_frame(10'b1001111000, 16, 640, -1, 40, "busy_ignore");
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin cycle(); if (busy1 !== 1'b0) busy_cnt++; end
    check("busy_ignore_no_second_frame", busy_cnt, 0);

    // Tick stall of 50 clocks in DATA.
    send(8'hC3, 1'b0, 1'b0);
    check_frame(10'b1110000110, 16, 688, 70, -1, "stall");
    repeat (5) cycle();

    // Reset during data bit 3 of 0x55.
    send(8'h55, 1'b0, 1'b0);
    k = 0; g = 0;
    while (k < 72 && g < 400) begin cycle(); if (tick_now) k++; g++; end
    check("rst_reached_bit3", k, 72);
    check("rst_pre_busy", busy1, 1);
    i_reset = 1'b0;
    cycle();
    check("rst_mid_tx", tx1, 1);
    check("rst_mid_busy", busy1, 0);
    check("rst_mid_done", done1, 0);
    i_reset = 1'b1;
    low_cnt = 0; busy_cnt = 0; dn_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      drive_tick();
      #1;
      if (done1 === 1'b1) dn_cnt++;
      @(posedge i_clk);
      #1;
      cyc++;
      if (tx1 !== 1'b1) low_cnt++;
      if (busy1 !== 1'b0) busy_cnt++;
    end
    check("rst_after_tx_low", low_cnt, 0);
    check("rst_after_busy", busy_cnt, 0);
    check("rst_after_done", dn_cnt, 0);
    send(8'h55, 1'b0, 1'b0);
    check_frame(10'b1010101010, 16, 640, -1, -1, "rst_resend");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
